// File: rtl/bcd_conv_sched_if.sv
// bcd_conv_sched_if: requester, converter and result signals of the shared BCD converter scheduler
interface bcd_conv_sched_if #(
   parameter int NREQ  = 4,
   parameter int BIN_W = 12,
   parameter int BCD_W = 16
);
   logic [NREQ-1:0]         req;
   logic [NREQ*BIN_W-1:0]   bin_in;
   logic [NREQ-1:0]         ack;
   logic                    conv_start;
   logic [BIN_W-1:0]        conv_bin;
   logic                    conv_done;
   logic [BCD_W-1:0]        conv_bcd;
   logic [NREQ*BCD_W-1:0]   res_bcd;
   logic [NREQ-1:0]         res_valid;
   logic                    res_stb;
   logic [$clog2(NREQ)-1:0] res_id;
   logic                    busy;
   logic                    timeout_err;

   modport master (
      input  req, bin_in, conv_done, conv_bcd,
      output ack, conv_start, conv_bin, res_bcd, res_valid, res_stb, res_id, busy, timeout_err
   );

   modport slave (
      output req, bin_in, conv_done, conv_bcd,
      input  ack, conv_start, conv_bin, res_bcd, res_valid, res_stb, res_id, busy, timeout_err
   );
endinterface

// File: rtl/bcd_conv_sched.sv
// bcd_conv_sched: round-robin sharing of one sequential binary-to-BCD converter among NREQ sources
module bcd_conv_sched #(
   parameter int NREQ    = 4,
   parameter int BIN_W   = 12,
   parameter int BCD_W   = 16,
   parameter int TIMEOUT = 64
) (
   input logic              clk,
   input logic              reset,
   bcd_conv_sched_if.master bus
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;

   logic [1:0]    state;
   logic [IW-1:0] last, gid, win, idx;
   logic [CW-1:0] cnt;
   logic          any;

   // round-robin winner: scan last+NREQ down to last+1 so the nearest pending requester is kept
   always_comb begin
      win = last;
      idx = last;
      any = 1'b0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = IW'((int'(last) + k) % NREQ);
         if (bus.req[idx]) begin
            win = idx;
            any = 1'b1;
         end
      end
   end

   // grant, converter handshake with timeout, and per-requester result capture
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state           <= IDLE;
         last            <= IW'(NREQ - 1);
         gid             <= '0;
         cnt             <= '0;
         bus.ack         <= '0;
         bus.conv_start  <= 1'b0;
         bus.conv_bin    <= '0;
         bus.res_bcd     <= '0;
         bus.res_valid   <= '0;
         bus.res_stb     <= 1'b0;
         bus.res_id      <= '0;
         bus.busy        <= 1'b0;
         bus.timeout_err <= 1'b0;
      end else begin
         bus.ack         <= '0;
         bus.conv_start  <= 1'b0;
         bus.res_stb     <= 1'b0;
         bus.timeout_err <= 1'b0;
         if (state == IDLE) begin
            if (any) begin
               state          <= START;
               gid            <= win;
               last           <= win;
               bus.conv_bin   <= bus.bin_in[int'(win)*BIN_W +: BIN_W];
               bus.ack        <= NREQ'(1) << win;
               bus.conv_start <= 1'b1;
               bus.busy       <= 1'b1;
            end
         end else if (state == START) begin
            state <= WAIT;
            cnt   <= '0;
         end else if (bus.conv_done) begin
            bus.res_bcd[int'(gid)*BCD_W +: BCD_W] <= bus.conv_bcd;
            bus.res_valid[gid] <= 1'b1;
            bus.res_stb        <= 1'b1;
            bus.res_id         <= gid;
            bus.busy           <= 1'b0;
            state              <= IDLE;
         end else if (cnt == CW'(TIMEOUT - 1)) begin
            bus.timeout_err <= 1'b1;
            bus.busy        <= 1'b0;
            state           <= IDLE;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

// File: tb/tb_bcd_conv_sched.sv
// tb_bcd_conv_sched: randomized transactions against a round-robin / decimal reference model
module tb_bcd_conv_sched;
   localparam int NREQ = 4, BIN_W = 12, BCD_W = 16, TIMEOUT = 64;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req_v = '0;
   logic [11:0] op [4];
   logic        done_v = 1'b0;
   logic [15:0] bcd_v = '0;
   int          n_cmp = 0, n_err = 0;

   int          m_last;
   logic [15:0] m_bcd [4];
   logic [3:0]  m_valid;
   logic [1:0]  m_id;

   bcd_conv_sched_if #(.NREQ(NREQ), .BIN_W(BIN_W), .BCD_W(BCD_W)) bus ();

   bcd_conv_sched #(.NREQ(NREQ), .BIN_W(BIN_W), .BCD_W(BCD_W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus.master)
   );

   assign bus.req       = req_v;
   assign bus.bin_in    = {op[3], op[2], op[1], op[0]};
   assign bus.conv_done = done_v;
   assign bus.conv_bcd  = bcd_v;

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   function automatic int rr_pick(input int last, input logic [3:0] r);
      for (int k = 1; k <= 4; k++)
         if (((r >> ((last + k) % 4)) & 4'd1) != 4'd0) return (last + k) % 4;
      return 0;
   endfunction

   function automatic logic [63:0] m_res();
      return {m_bcd[3], m_bcd[2], m_bcd[1], m_bcd[0]};
   endfunction

   task automatic chk_zero(input string tag);
      chk(tag, 96'({bus.ack, bus.conv_start, bus.conv_bin, bus.res_bcd, bus.res_valid,
                    bus.res_stb, bus.res_id, bus.busy, bus.timeout_err}), 96'(0));
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      req_v  = '0;
      done_v = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk_zero("reset_outputs");
      reset   = 1'b0;
      m_last  = 3;
      m_valid = '0;
      m_id    = '0;
      for (int i = 0; i < 4; i++) m_bcd[i] = '0;
   endtask

   // one granted conversion; called at a negedge of an IDLE cycle with req_v already driven
   task automatic txn(input int lat, input bit hold, input bit stray);
      int w, n;
      logic [11:0] v;
      bit e_stb, e_err, e_idle;
      w = rr_pick(m_last, req_v);
      v = op[w];
      @(negedge clk);
      chk("ack", 96'(bus.ack), 96'(4'b0001 << w));
      chk("conv_start", 96'(bus.conv_start), 96'(1));
      chk("conv_bin", 96'(bus.conv_bin), 96'(v));
      chk("busy_start", 96'(bus.busy), 96'(1));
      m_last = w;
      if (!hold) req_v[w] = 1'b0;
      done_v = stray;
      bcd_v  = 16'($urandom);
      e_stb = 0; e_err = 0; e_idle = 0;
      n = (lat < TIMEOUT) ? lat : TIMEOUT;
      for (int j = 1; j <= n; j++) begin
         @(negedge clk);
         if (j == 1) chk("ack_pulse", 96'({bus.ack, bus.conv_start}), 96'(0));
         e_stb  |= bus.res_stb;
         e_err  |= bus.timeout_err;
         e_idle |= !bus.busy;
         done_v = (j == lat);
         bcd_v  = (j == lat) ? bcd(int'(v)) : 16'($urandom);
      end
      @(negedge clk);
      done_v = 1'b0;
      chk("wait_quiet", 96'({e_stb, e_err, e_idle}), 96'(0));
      if (lat <= TIMEOUT) begin
         m_bcd[w]   = bcd(int'(v));
         m_valid[w] = 1'b1;
         m_id       = 2'(w);
      end
      chk("res_stb", 96'(bus.res_stb), 96'(lat <= TIMEOUT));
      chk("timeout_err", 96'(bus.timeout_err), 96'(lat > TIMEOUT));
      chk("res_id", 96'(bus.res_id), 96'(m_id));
      chk("res_bcd", 96'(bus.res_bcd), 96'(m_res()));
      chk("res_valid", 96'(bus.res_valid), 96'(m_valid));
      chk("busy_idle", 96'(bus.busy), 96'(0));
   endtask

   initial begin
      logic [3:0] mask;
      for (int i = 0; i < 4; i++) op[i] = '0;
      do_reset();

      op[0] = 12'd255; req_v = 4'b0001;
      txn(30, 0, 0);
      chk("first_result", 96'(bus.res_bcd[15:0]), 96'(16'h0255));

      do_reset();
      for (int i = 0; i < 4; i++) op[i] = 12'($urandom_range(0, 4095));
      req_v = 4'b1111;
      for (int t = 0; t < 5; t++) txn($urandom_range(1, 20), 1, 0);
      req_v = '0;

      do_reset();
      op[2] = 12'd999; req_v = 4'b0100;
      txn(4, 0, 0);
      op[0] = 12'd1234; req_v = 4'b0101;
      txn(3, 0, 0);
      txn(2, 0, 0);

      op[1] = 12'd77; req_v = 4'b0010;
      txn(1000, 0, 0);
      op[1] = 12'd78; req_v = 4'b0010;
      txn(5, 0, 0);

      op[3] = 12'd4095; req_v = 4'b1000;
      txn(TIMEOUT, 0, 1);

      done_v = 1'b1; bcd_v = 16'h9999;
      @(negedge clk);
      done_v = 1'b0;
      chk("idle_done_stb", 96'(bus.res_stb), 96'(0));
      chk("idle_done_res", 96'(bus.res_bcd), 96'(m_res()));

      for (int t = 0; t < 25; t++) begin
         mask = 4'($urandom_range(1, 15));
         for (int i = 0; i < 4; i++) if (!req_v[i]) op[i] = 12'($urandom_range(0, 4095));
         req_v = mask;
         txn(($urandom_range(0, 7) == 0) ? 200 : $urandom_range(1, TIMEOUT), 0, 1'($urandom_range(0, 1)));
      end

      req_v = 4'b0100; op[2] = 12'd42;
      @(negedge clk);
      req_v = '0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      chk_zero("async_reset");
      @(negedge clk);
      reset  = 1'b0;
      m_last = 3; m_valid = '0; m_id = '0;
      for (int i = 0; i < 4; i++) m_bcd[i] = '0;
      done_v = 1'b1; bcd_v = 16'h0042;
      @(negedge clk);
      done_v = 1'b0;
      chk("late_done", 96'({bus.res_stb, bus.res_valid, bus.busy}), 96'(0));
      op[0] = 12'd500; op[3] = 12'd600; req_v = 4'b1001;
      txn(6, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
